cpe_lin_adder_pipe: RTL

Pipelined, parametrised successor of the combinational linearised-adder/CPE encoder. It accepts adder operands plus the externally computed non-linear XOR-chain terms and reconstructs the NBIT+1-bit sum. It then encodes the low NBIT sum bits into a systematic CPE codeword using a parameter-supplied parity matrix. It sits between the non-linear term generator and the error-detection checker, with valid/ready flow control and a 2-stage pipeline.

---
 rtl/cpe_lin_adder_pipe_if.sv | 43 ++++
 rtl/cpe_lin_adder_pipe.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cpe_lin_adder_pipe_if.sv
// ----------------------------------------------------------------------------
// cpe_lin_adder_pipe_if
// Bundles the valid/ready handshake and data signals of cpe_lin_adder_pipe.
//   master : traffic source/sink (drives in_valid, a, b, n, out_ready)
//   slave  : the pipeline (drives in_ready, out_valid, code, cout, word_cnt)
// Signals:
//   in_valid/in_ready   input handshake
//   a, b                NBIT-bit adder operands
//   n                   NNL-bit non-linear XOR-chain term vector
//   out_valid/out_ready output handshake
//   code                NCODE-bit codeword {parity, s[NBIT-1:0]}
//   cout                sum bit s[NBIT]
//   word_cnt            count of accepted output words (wraps)
// ----------------------------------------------------------------------------
interface cpe_lin_adder_pipe_if #(
    parameter int unsigned NBIT = 7,
    parameter int unsigned NPAR = 8,
    parameter int unsigned CNTW = 16
);
    localparam int unsigned NCODE = NBIT + NPAR;
    localparam int unsigned NNL   = 2 ** (NBIT + 2) - NBIT - 4;

    logic             in_valid;
    logic             in_ready;
    logic [NBIT-1:0]  a;
    logic [NBIT-1:0]  b;
    logic [NNL-1:0]   n;
    logic             out_valid;
    logic             out_ready;
    logic [NCODE-1:0] code;
    logic             cout;
    logic [CNTW-1:0]  word_cnt;

    modport master (
        output in_valid, a, b, n, out_ready,
        input  in_ready, out_valid, code, cout, word_cnt
    );

    modport slave (
        input  in_valid, a, b, n, out_ready,
        output in_ready, out_valid, code, cout, word_cnt
    );
endinterface

// File: rtl/cpe_lin_adder_pipe.sv
// ----------------------------------------------------------------------------
// cpe_lin_adder_pipe
// Two-stage pipelined linearised adder + systematic CPE encoder.
//   S1: reconstruct s[NBIT:0] from a, b and the non-linear term vector n.
//   S2: compute parity from s[NBIT-1:0] and register {parity, s} and carry.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   fault_mask XOR mask applied to code at the S2 load (CPE_FAULT_INJ_EN only)
//   bus_io     slave side of cpe_lin_adder_pipe_if (handshakes, data, counter)
// Optional feature macro: CPE_FAULT_INJ_EN (adds fault_mask port).
// ----------------------------------------------------------------------------
module cpe_lin_adder_pipe #(
    parameter int unsigned        NBIT  = 7,
    parameter int unsigned        NPAR  = 8,
    parameter int unsigned        CNTW  = 16,
    // Row j occupies [j*NBIT +: NBIT]; row 0 is the least significant.
    parameter logic [NPAR*NBIT-1:0] PMASK = {7'h45, 7'h67, 7'h76, 7'h3B,
                                             7'h58, 7'h2C, 7'h16, 7'h0B}
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CPE_FAULT_INJ_EN
    input  logic [NBIT+NPAR-1:0] fault_mask,
`endif
    cpe_lin_adder_pipe_if.slave  bus_io
);
    localparam int unsigned NCODE = NBIT + NPAR;

    // ------------------------------------------------------------------
    // Linear reconstruction: each sum bit above 0 folds in its own
    // contiguous odd-length segment of the non-linear term vector.
    // ------------------------------------------------------------------
    logic [NBIT:1] seg_x;
    logic [NBIT:0] sum_c;

    for (genvar i = 1; i <= NBIT; i++) begin : g_seg
        localparam int unsigned Off = 2 ** (i + 1) - i - 3;
        localparam int unsigned Len = 2 ** (i + 1) - 1;
        assign seg_x[i] = ^bus_io.n[Off +: Len];
    end

    always_comb begin
        sum_c       = '0;
        sum_c[0]    = bus_io.a[0] ^ bus_io.b[0];
        for (int i = 1; i < NBIT; i++) begin
            sum_c[i] = bus_io.a[i] ^ bus_io.b[i] ^ seg_x[i];
        end
        sum_c[NBIT] = seg_x[NBIT];
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_v_q,      s1_v_d;
    logic [NBIT:0]    s1_sum_q,    s1_sum_d;
    logic             out_valid_q, out_valid_d;
    logic [NCODE-1:0] code_q,      code_d;
    logic             cout_q,      cout_d;
    logic [CNTW-1:0]  cnt_q,       cnt_d;

    logic             in_ready;
    logic             s1_load;
    logic             s2_load;
    logic             out_fire;
    logic [NPAR-1:0]  parity;

    // Parity over the registered S1 sum; carry bit is deliberately excluded.
    for (genvar j = 0; j < NPAR; j++) begin : g_par
        assign parity[j] = ^(s1_sum_q[NBIT-1:0] & PMASK[j*NBIT +: NBIT]);
    end

    // No skid buffer: S1 may accept only if it is empty or will move on.
    assign in_ready = !s1_v_q || !out_valid_q || bus_io.out_ready;
    assign s1_load  = bus_io.in_valid && in_ready;
    assign s2_load  = s1_v_q && (!out_valid_q || bus_io.out_ready);
    assign out_fire = out_valid_q && bus_io.out_ready;

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_sum_d    = s1_sum_q;
        out_valid_d = out_valid_q;
        code_d      = code_q;
        cout_d      = cout_q;
        cnt_d       = cnt_q;

        // Fill wins over drain so a simultaneous drain/fill keeps valid high.
        if (s1_load) begin
            s1_v_d   = 1'b1;
            s1_sum_d = sum_c;
        end else if (s2_load) begin
            s1_v_d   = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
`ifdef CPE_FAULT_INJ_EN
            code_d      = {parity, s1_sum_q[NBIT-1:0]} ^ fault_mask;
`else
            code_d      = {parity, s1_sum_q[NBIT-1:0]};
`endif
            cout_d      = s1_sum_q[NBIT];
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            cout_q      <= cout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.code      = code_q;
    assign bus_io.cout      = cout_q;
    assign bus_io.word_cnt  = cnt_q;
endmodule
